// File: rtl/handshake_constant_arbiter_if.sv
// Handshake bundle for handshake_constant_arbiter: requester control tokens
// in, constant token plus requester tag out.
// master: the arbiter side. slave: the requester/downstream side.
interface handshake_constant_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  localparam int TAG_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    ctrl_valid;
  logic [NUM_REQ-1:0]    ctrl_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic [TAG_WIDTH-1:0]  outs_tag;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    input  ctrl_valid,
    output ctrl_ready,
    output outs,
    output outs_tag,
    output outs_valid,
    input  outs_ready
  );

  modport slave (
    output ctrl_valid,
    input  ctrl_ready,
    input  outs,
    input  outs_tag,
    input  outs_valid,
    output outs_ready
  );
endinterface

// File: rtl/handshake_constant_arbiter.sv
// handshake_constant_arbiter: one elastic constant source shared by NUM_REQ
// control channels. A round-robin arbiter accepts at most one token per
// cycle into a one-entry output register that carries CONST_VALUE and the
// winning requester's index as a tag.
// Optional build macro HANDSHAKE_CONST_ARB_FIXED_PRIO_EN: drop the
// round-robin pointer and grant the lowest valid index instead.
module handshake_constant_arbiter #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_REQ     = 4,
  parameter logic [31:0] CONST_VALUE = 32'h04AA001B
) (
  input logic                          clk,
  input logic                          rst,
  handshake_constant_arbiter_if.master bus
);
  localparam int TAG_WIDTH = $clog2(NUM_REQ);
  localparam logic [TAG_WIDTH-1:0] LAST_IDX = TAG_WIDTH'(NUM_REQ - 1);

  logic                 full;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [TAG_WIDTH-1:0] grant;
  logic                 grant_found;
  logic                 space;
  logic                 accept;
  logic [NUM_REQ-1:0]   ready;

  assign space  = !full || bus.outs_ready;
  assign accept = |ready;

`ifndef HANDSHAKE_CONST_ARB_FIXED_PRIO_EN
  logic [TAG_WIDTH-1:0] ptr;

  // Round-robin search: first valid index at ptr, ptr+1, ... mod NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && bus.ctrl_valid[TAG_WIDTH'(idx)]) begin
        grant_found = 1'b1;
        grant       = TAG_WIDTH'(idx);
      end
    end
  end

  // Pointer moves just past the accepted requester, wrapping explicitly so
  // non-power-of-two NUM_REQ never reaches an unused index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant == LAST_IDX) ? '0 : grant + TAG_WIDTH'(1);
    end
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && bus.ctrl_valid[k]) begin
        grant_found = 1'b1;
        grant       = TAG_WIDTH'(k);
      end
    end
  end
`endif

  // One-hot accept for the granted requester; held at zero while in reset.
  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ready[i] = rst && space && grant_found && (grant == TAG_WIDTH'(i));
    end
  end

  // Output register: fill on accept, empty on drain without a refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full  <= 1'b0;
      tag_q <= '0;
    end else if (accept) begin
      full  <= 1'b1;
      tag_q <= grant;
    end else if (bus.outs_ready) begin
      full  <= 1'b0;
    end
  end

  assign bus.ctrl_ready = ready;
  assign bus.outs       = DATA_WIDTH'(CONST_VALUE);
  assign bus.outs_tag   = tag_q;
  assign bus.outs_valid = full;

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Self-checking bench for handshake_constant_arbiter: a reference model
// predicts ctrl_ready and the tag of each accepted token; accepted tags are
// queued and compared when the DUT drains them downstream.
module tb_handshake_constant_arbiter;
  localparam int          DW   = 32;
  localparam int          NREQ = 4;
  localparam int          TW   = $clog2(NREQ);
  localparam logic [31:0] CVAL = 32'h04AA001B;

  logic clk;
  logic rst;

  int checks;
  int failures;

  int m_full;
  int m_tag;
  int m_ptr;
  int sb_q[$];

  handshake_constant_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NREQ)) bus ();

  handshake_constant_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NREQ),
    .CONST_VALUE(CVAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
    int idx;
`ifndef HANDSHAKE_CONST_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (v[idx]) return idx;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      idx = k;
      if (v[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 0;
    m_tag  = 0;
    m_ptr  = 0;
    sb_q.delete();
  endtask

  // Drive one cycle at the negedge, check just after, then advance the model
  // across the rising edge.
  task automatic step(input logic [NREQ-1:0] v, input logic r);
    int               g;
    logic [NREQ-1:0]  exp_ready;
    logic             acc;
    int               t;
    bus.ctrl_valid = v;
    bus.outs_ready = r;
    #1;
    g         = model_grant(v, m_ptr);
    exp_ready = '0;
    if ((m_full == 0 || r) && g >= 0) exp_ready[g] = 1'b1;
    acc = |exp_ready;
    check("ctrl_ready", bus.ctrl_ready, exp_ready);
    check("outs_valid", bus.outs_valid, m_full);
    check("outs_const", bus.outs, CVAL);
    if (m_full != 0) check("outs_tag_held", bus.outs_tag, m_tag);
    if (bus.outs_valid && r) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_token", 1, 0);
      end else begin
        t = sb_q.pop_front();
        check("sb_tag", bus.outs_tag, t);
      end
    end
    if (acc) sb_q.push_back(g);
    @(posedge clk);
    if (acc) begin
      m_full = 1;
      m_tag  = g;
      m_ptr  = (g + 1) % NREQ;
    end else if (r) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();

    // Reset held: outputs quiet even with every requester valid.
    rst            = 1'b0;
    bus.ctrl_valid = '1;
    bus.outs_ready = 1'b1;
    #12;
    check("rst_outs_valid", bus.outs_valid, 0);
    check("rst_outs_tag", bus.outs_tag, 0);
    check("rst_ctrl_ready", bus.ctrl_ready, 0);
    @(negedge clk);
    rst = 1'b1;

    // Idle requesters.
    repeat (5) step(4'b0000, 1'b1);

    // All valid: tags 0,1,2,3,0,1 (round-robin) with one ready bit per cycle.
    repeat (6) step(4'b1111, 1'b1);

    // Alternating 1,3.
    repeat (5) step(4'b1010, 1'b1);

    // Accept tag 2, stall 4 cycles, then release: next grant in same cycle.
    step(4'b0100, 1'b1);
    repeat (4) step(4'b1111, 1'b0);
    repeat (3) step(4'b1111, 1'b1);

    // Asynchronous reset while full.
    step(4'b1111, 1'b0);
    check("pre_rst_full", bus.outs_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_outs_valid", bus.outs_valid, 0);
    check("async_rst_outs_tag", bus.outs_tag, 0);
    check("async_rst_ctrl_ready", bus.ctrl_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (4) step(4'b1111, 1'b1);

    // Random traffic with random backpressure.
    for (int n = 0; n < 300; n++) begin
      step(NREQ'($urandom_range(0, (1 << NREQ) - 1)), 1'($urandom_range(0, 1)));
    end

    // Drain everything still held.
    repeat (3) step(4'b0000, 1'b1);
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
